// File: rtl/pc_control_pkg.sv
// Shared CPU constants for the program-counter block: next-PC select codes,
// default reset/exception addresses and the target-mux result bundle.
package pc_control_pkg;

  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;
  localparam logic [1:0] PC_SRC_RSV = 2'b11;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_00FF;

  typedef struct packed {
    logic [31:0] next_pc;
    logic        sel_bad;
    logic        misaligned;
  } target_t;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC generation: PC+4, jump target, select, and the
// selection/alignment legality checks applied before any PC write.
module pc_target_mux
  import pc_control_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] btr,
  input  logic        bt_valid,
  input  logic [25:0] instr_index,
  input  logic [1:0]  pc_source,
  output target_t     tgt
);

  logic [31:0] pc_inc;
  logic [31:0] jump_target;

  assign pc_inc      = pc + 32'd4;
  assign jump_target = {pc[31:28], instr_index, 2'b00};

  always_comb begin
    tgt = '0;
    case (pc_source)
      PC_SRC_INC: tgt.next_pc = pc_inc;
      PC_SRC_BR: begin
        tgt.next_pc = btr;
        // Branch target is only meaningful once captured and not yet consumed.
        tgt.sel_bad = ~bt_valid;
      end
      PC_SRC_JMP: tgt.next_pc = jump_target;
      default: begin
        tgt.next_pc = pc;
        tgt.sel_bad = 1'b1;
      end
    endcase
    tgt.misaligned = (tgt.next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_control.sv
// Program counter, branch target and exception PC registers with
// legality checks on every PC write and a one-cycle deferred misalign trap.
module pc_control
  import pc_control_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] shift_left_out,
  input  logic [25:0] instr_index,
  input  logic        bt_load,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic [1:0]  pc_source,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        bt_valid,
  output logic        misalign_exc,
  output logic        sel_err
);

  logic [31:0] btr;
  target_t     tgt;
  logic        take;
  logic        exc_now;

  pc_target_mux u_mux (
    .pc          (pc),
    .btr         (btr),
    .bt_valid    (bt_valid),
    .instr_index (instr_index),
    .pc_source   (pc_source),
    .tgt         (tgt)
  );

  assign take = pc_write | (pc_write_cond & (zero ^ branch_ne));
  // The misalign pulse doubles as the pending internal exception request.
  assign exc_now = exc_req | misalign_exc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      epc          <= 32'd0;
      btr          <= 32'd0;
      bt_valid     <= 1'b0;
      misalign_exc <= 1'b0;
      sel_err      <= 1'b0;
    end else if (exc_now) begin
      epc          <= pc - 32'd4;
      pc           <= EXC_VECTOR;
      bt_valid     <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      misalign_exc <= 1'b0;
      if (take) begin
        if (tgt.sel_bad) begin
          sel_err <= 1'b1;
        end else if (tgt.misaligned) begin
          misalign_exc <= 1'b1;
        end else begin
          pc       <= tgt.next_pc;
          bt_valid <= 1'b0;
        end
      end
      // A same-cycle capture wins over the consume-clear above.
      if (bt_load) begin
        btr      <= pc + shift_left_out;
        bt_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed vector table plus a
// randomized run against a behavioural next-state model.
module tb_pc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] shift_left_out;
  logic [25:0] instr_index;
  logic        bt_load, pc_write, pc_write_cond, branch_ne, zero, exc_req;
  logic [1:0]  pc_source;
  logic [31:0] pc, epc;
  logic        bt_valid, misalign_exc, sel_err;

  int errors = 0;
  int checks = 0;

  pc_control dut (
    .clk(clk), .reset(reset), .shift_left_out(shift_left_out),
    .instr_index(instr_index), .bt_load(bt_load), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .zero(zero),
    .pc_source(pc_source), .exc_req(exc_req), .pc(pc), .epc(epc),
    .bt_valid(bt_valid), .misalign_exc(misalign_exc), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, btl, pw, pwc, ne, zr, exc;
    logic [1:0]  src;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] e_pc, e_epc;
    logic        e_btv, e_mis, e_sel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, btl, pw, pwc, ne, zr, input logic [1:0] src,
                     input logic exc, input logic [31:0] off, input logic [25:0] idx,
                     input logic [31:0] e_pc, e_epc, input logic e_btv, e_mis, e_sel);
    vec_t v;
    v.rst = rst; v.btl = btl; v.pw = pw; v.pwc = pwc; v.ne = ne; v.zr = zr;
    v.src = src; v.exc = exc; v.off = off; v.idx = idx;
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_btv = e_btv; v.e_mis = e_mis; v.e_sel = e_sel;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, btl, pw, pwc, ne, zr, input logic [1:0] src,
                       input logic exc, input logic [31:0] off, input logic [25:0] idx);
    @(negedge clk);
    reset = rst; bt_load = btl; pc_write = pw; pc_write_cond = pwc;
    branch_ne = ne; zero = zr; pc_source = src; exc_req = exc;
    shift_left_out = off; instr_index = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int row, input logic [31:0] w_pc, w_epc,
                       input logic w_btv, w_mis, w_sel);
    checks++;
    if (pc !== w_pc || epc !== w_epc || bt_valid !== w_btv ||
        misalign_exc !== w_mis || sel_err !== w_sel) begin
      errors++;
      $display("FAIL %s row %0d: got pc=%h epc=%h btv=%b mis=%b sel=%b, want pc=%h epc=%h btv=%b mis=%b sel=%b",
               name, row, pc, epc, bt_valid, misalign_exc, sel_err,
               w_pc, w_epc, w_btv, w_mis, w_sel);
    end
  endtask

  // Reference model state, advanced one clock at a time from the rules.
  logic [31:0] m_pc, m_epc, m_btr;
  logic        m_btv, m_mis, m_sel;

  task automatic model_step(input logic rst, btl, pw, pwc, ne, zr, input logic [1:0] src,
                            input logic exc, input logic [31:0] off, input logic [25:0] idx);
    logic [31:0] old_pc, target;
    logic        take, bad;
    old_pc = m_pc;
    if (rst) begin
      m_pc = 0; m_epc = 0; m_btr = 0; m_btv = 0; m_mis = 0; m_sel = 0;
    end else if (exc || m_mis) begin
      m_epc = old_pc - 4; m_pc = 32'hFF; m_btv = 0; m_mis = 0;
    end else begin
      m_mis  = 0;
      take   = pw || (pwc && (zr != ne));
      target = (src == 0) ? old_pc + 4 :
               (src == 1) ? m_btr :
               ((old_pc & 32'hF000_0000) | (32'(idx) * 4));
      bad    = (src == 3) || (src == 1 && !m_btv);
      if (take && bad) m_sel = 1;
      else if (take && (target % 4) != 0) m_mis = 1;
      else if (take) begin m_pc = target; m_btv = 0; end
      if (btl) begin m_btr = old_pc + off; m_btv = 1; end
    end
  endtask

  initial begin
    reset = 1; bt_load = 0; pc_write = 0; pc_write_cond = 0; branch_ne = 0;
    zero = 0; pc_source = 0; exc_req = 0; shift_left_out = 0; instr_index = 0;

    //   rst btl pw pwc ne zr src  exc off            idx    pc            epc       btv mis sel
    add(1, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'h0,        32'h0,    0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'h4,        32'h0,    0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'h8,        32'h0,    0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'hC,        32'h0,    0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd2, 0, 32'h0,         26'h40, 32'h100,      32'h0,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 2'd0, 0, 32'h20,        26'h0,  32'h100,      32'h0,    1, 0, 0);
    add(0, 0, 0, 1, 0, 1, 2'd1, 0, 32'h0,         26'h0,  32'h120,      32'h0,    0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd2, 0, 32'h0,         26'h40, 32'h100,      32'h0,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 2'd0, 0, 32'h20,        26'h0,  32'h100,      32'h0,    1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 2'd1, 0, 32'h0,         26'h0,  32'h100,      32'h0,    1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 2'd1, 0, 32'h0,         26'h0,  32'h120,      32'h0,    0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd2, 0, 32'h0,         26'h40, 32'h100,      32'h0,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 2'd0, 0, 32'h2,         26'h0,  32'h100,      32'h0,    1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd1, 0, 32'h0,         26'h0,  32'h100,      32'h0,    1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'hFF,       32'hFC,   0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'h0,        32'h0,    0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd2, 0, 32'h0,         26'h80, 32'h200,      32'h0,    0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd0, 1, 32'h0,         26'h0,  32'hFF,       32'h1FC,  0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd3, 0, 32'h0,         26'h0,  32'hFF,       32'h1FC,  0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'hFF,       32'h1FC,  0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 2'd1, 0, 32'h0,         26'h0,  32'hFF,       32'h1FC,  0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'hFF,       32'h1FC,  0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'hFF,       32'hFB,   0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'h0,        32'h0,    0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 2'd0, 1, 32'h10,        26'h0,  32'h0,        32'h0,    0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'h0,        32'h0,    0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 2'd0, 0, 32'h8,         26'h0,  32'h4,        32'h0,    1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd1, 0, 32'h0,         26'h0,  32'h8,        32'h0,    0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'hC,        32'h0,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 2'd0, 0, 32'h4000_0004, 26'h0,  32'hC,        32'h0,    1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd1, 0, 32'h0,         26'h0,  32'h4000_0010, 32'h0,   0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd2, 0, 32'h0,         26'h40, 32'h4000_0100, 32'h0,   0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 2'd0, 0, 32'hBFFF_FEFC, 26'h0,  32'h4000_0100, 32'h0,   1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd1, 0, 32'h0,         26'h0,  32'hFFFF_FFFC, 32'h0,   0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd0, 0, 32'h0,         26'h0,  32'h0,        32'h0,    0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].btl, vecs[i].pw, vecs[i].pwc, vecs[i].ne, vecs[i].zr,
            vecs[i].src, vecs[i].exc, vecs[i].off, vecs[i].idx);
      check("vec", i, vecs[i].e_pc, vecs[i].e_epc, vecs[i].e_btv, vecs[i].e_mis, vecs[i].e_sel);
    end

    // Randomized run; first cycle forces reset so model and DUT align.
    for (int n = 0; n < 600; n++) begin
      logic        r_rst, r_btl, r_pw, r_pwc, r_ne, r_zr, r_exc;
      logic [1:0]  r_src;
      logic [31:0] r_off;
      logic [25:0] r_idx;
      r_rst = (n == 0) || ($urandom_range(0, 39) == 0);
      r_btl = ($urandom_range(0, 2) == 0);
      r_pw  = ($urandom_range(0, 3) == 0);
      r_pwc = ($urandom_range(0, 3) == 0);
      r_ne  = 1'($urandom);
      r_zr  = 1'($urandom);
      r_exc = ($urandom_range(0, 19) == 0);
      r_src = 2'($urandom);
      r_off = $urandom;
      if ($urandom_range(0, 3) != 0) r_off[1:0] = 2'b00;
      r_idx = 26'($urandom);
      drive(r_rst, r_btl, r_pw, r_pwc, r_ne, r_zr, r_src, r_exc, r_off, r_idx);
      model_step(r_rst, r_btl, r_pw, r_pwc, r_ne, r_zr, r_src, r_exc, r_off, r_idx);
      check("rand", n, m_pc, m_epc, m_btv, m_mis, m_sel);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
